hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 42 ++++
 rtl/hazard_ctrl_fwd_sel.sv | 29 ++
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Pipe_Buf_Reg_PKG
// Pipeline buffer typedefs shared by the pipeline stages, plus the hazard
// controller's FSM state enum and forwarding-select encodings.
// Contents:
//   if_id_reg, id_ex_reg, ex_mem_reg, mem_wb_reg : packed stage buffers
//   hazard_state_e                              : RUN / DRAIN / HALTED
//   FWD_RF / FWD_WB / FWD_MEM                    : EX operand source select
package Pipe_Buf_Reg_PKG;

    typedef struct packed {
        logic [31:0] Curr_Instr;
    } if_id_reg;

    typedef struct packed {
        logic       MemRead;
        logic       flag_halt;
        logic [4:0] RS_One;
        logic [4:0] RS_Two;
        logic [4:0] rd;
    } id_ex_reg;

    typedef struct packed {
        logic       RegWrite;
        logic [4:0] rd;
    } ex_mem_reg;

    typedef struct packed {
        logic       RegWrite;
        logic [4:0] rd;
    } mem_wb_reg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hazard_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel
// Combinational forwarding selector for one EX operand.
// Ports:
//   rs      in  : source register index of the operand in ID/EX
//   ex_mem  in  : EX/MEM buffer (RegWrite, rd)
//   mem_wb  in  : MEM/WB buffer (RegWrite, rd)
//   sel     out : FWD_MEM, FWD_WB or FWD_RF
import Pipe_Buf_Reg_PKG::*;

module fwd_sel (
    input  logic [4:0] rs,
    input  ex_mem_reg  ex_mem,
    input  mem_wb_reg  mem_wb,
    output logic [1:0] sel
);

    // The younger result in EX/MEM wins over MEM/WB, so it is tested last.
    // Register x0 is never forwarded since it always reads as zero.
    always_comb begin
        sel = FWD_RF;
        if (mem_wb.RegWrite && (mem_wb.rd != 5'd0) && (mem_wb.rd == rs)) begin
            sel = FWD_WB;
        end
        if (ex_mem.RegWrite && (ex_mem.rd != 5'd0) && (ex_mem.rd == rs)) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller: operand forwarding, load-use stalls, branch
// flushes and a halt sequence that drains the pipeline into HALTED.
// Parameters:
//   DRAIN_CYCLES : cycles spent in DRAIN before HALTED
//   CNT_W        : width of the performance counters
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   if_id, id_ex, ex_mem, mem_wb    : pipeline buffer contents
//   branch_taken                    : EX-stage redirect
//   pc_write, ifid_write            : PC / IF-ID enables
//   flush_ifid, flush_idex          : IF-ID / ID-EX clears
//   fwd_a, fwd_b                    : EX operand selects
//   halted                          : machine is halted
//   stall_cnt, flush_cnt            : performance counters
// Build option: define HAZARD_PERF_CNT_EN to implement the performance
// counters; otherwise they read constant zero and no counter flops exist.
import Pipe_Buf_Reg_PKG::*;

module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  if_id_reg         if_id,
    input  id_ex_reg         id_ex,
    input  ex_mem_reg        ex_mem,
    input  mem_wb_reg        mem_wb,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    hazard_state_e state, state_next;
    logic [DW-1:0] drain_cnt, drain_next;
    logic [1:0]    sel_a, sel_b;
    logic          load_use;
    logic          stall_evt, flush_evt;
    logic          unused_instr_bits;

    fwd_sel u_fwd_a (.rs(id_ex.RS_One), .ex_mem(ex_mem), .mem_wb(mem_wb), .sel(sel_a));
    fwd_sel u_fwd_b (.rs(id_ex.RS_Two), .ex_mem(ex_mem), .mem_wb(mem_wb), .sel(sel_b));

    assign load_use = id_ex.MemRead && (id_ex.rd != 5'd0) &&
                      ((id_ex.rd == if_id.Curr_Instr[19:15]) ||
                       (id_ex.rd == if_id.Curr_Instr[24:20]));

    assign unused_instr_bits = ^{if_id.Curr_Instr[31:25], if_id.Curr_Instr[14:0]};

    // State register and drain countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
        end
    end

    // Next state and control outputs. Priority in RUN is halt, then branch,
    // then load-use. Reset overrides everything so the pipeline is cleared
    // while the machine restarts.
    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        fwd_a      = sel_a;
        fwd_b      = sel_b;
        halted     = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        case (state)
            RUN: begin
                if (id_ex.flag_halt) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    state_next = DRAIN;
                    drain_next = DW'(DRAIN_CYCLES - 1);
                end else if (branch_taken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    flush_evt  = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    flush_idex = 1'b1;
                    stall_evt  = 1'b1;
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                if (drain_cnt == '0) begin
                    state_next = HALTED;
                end else begin
                    drain_next = drain_cnt - DW'(1);
                end
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                fwd_a      = FWD_RF;
                fwd_b      = FWD_RF;
                halted     = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (reset) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            fwd_a      = FWD_RF;
            fwd_b      = FWD_RF;
            halted     = 1'b0;
            stall_evt  = 1'b0;
            flush_evt  = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Event counters; events only fire in RUN, so DRAIN/HALTED freeze them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_evt) stall_q <= stall_q + CNT_W'(1);
            if (flush_evt) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_evt;

    assign unused_evt = stall_evt ^ flush_evt;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
`endif

endmodule
